dmem_responder: RTL and testbench

- Data-memory responder on the far end of the core's load/store interface (data_addr, data_write, MemOp, MemWe, data_read).
- Adds a valid/ready request and response handshake and a configurable wait-state counter, so a multi-cycle core can be tested against slow memory.
- Holds a byte-addressable word array and performs RV32 byte-lane alignment, write masking and sign/zero extension inside the block.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [2:0]  MemOp;
  logic        MemWe;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] data_read;
  logic        resp_err;

  modport master (
    output req_valid, data_addr, data_write, MemOp, MemWe, resp_ready,
    input  req_ready, resp_valid, data_read, resp_err
  );

  modport slave (
    input  req_valid, data_addr, data_write, MemOp, MemWe, resp_ready,
    output req_ready, resp_valid, data_read, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Valid/ready RV32 data memory with WAIT_CYCLES wait states; accept->resp_valid is WAIT_CYCLES+2 cycles.
// One request in flight: req_ready stays low until the response is taken. Macro DMEM_MISALIGN_ERR_EN flags misaligned accesses.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clock,
  input logic             reset,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
  localparam int CW    = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic                accept;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            op_q;
  logic                  we_q;

  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-3:0] idx;
  logic [1:0]            off;
  logic [1:0]            lane;
  logic                  is_byte, is_half, is_word;
  logic                  blocked;
  logic                  commit;
  logic [3:0]            be;
  logic [31:0]           wlane;
  logic [31:0]           rword;
  logic [31:0]           shifted;
  logic [31:0]           load_val;
  logic [31:0]           data_read_q;

  assign accept         = bus.req_valid && (state == IDLE);
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.data_read  = data_read_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CW'(1);
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == CW'(WAIT_CYCLES)) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ACCESS: state_nxt = RESP;
      RESP: begin
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at accept so the core may move on immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.data_addr[ADDR_WIDTH-1:0];
      wdata_q <= bus.data_write;
      op_q    <= bus.MemOp;
      we_q    <= bus.MemWe;
    end
  end

  assign idx     = addr_q[ADDR_WIDTH-1:2];
  assign off     = addr_q[1:0];
  assign is_byte = (op_q[1:0] == 2'b00);
  assign is_half = (op_q[1:0] == 2'b01);
  assign is_word = !is_byte && !is_half;
  assign commit  = (state == ACCESS);

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_q;

  assign lane        = off;
  assign blocked     = (is_half && off[0]) || (is_word && (off != 2'b00));
  assign bus.resp_err = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       err_q <= 1'b0;
    else if (commit) err_q <= blocked;
  end
`else
  // Misaligned halves/words are silently snapped down to their natural boundary.
  assign lane         = is_word ? 2'b00 : (is_half ? {off[1], 1'b0} : off);
  assign blocked      = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_comb begin
    be    = 4'hF;
    wlane = wdata_q;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wlane = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << lane;
      wlane = {2{wdata_q[15:0]}};
    end
  end

  always_ff @(posedge clock) begin
    if (commit && we_q && !blocked) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  assign rword   = mem[idx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    load_val = shifted;
    if (is_byte) begin
      load_val = op_q[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_val = op_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    end
  end

  // Captured on the edge leaving ACCESS and held through RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       data_read_q <= '0;
    else if (commit) data_read_q <= (we_q || blocked) ? 32'b0 : load_val;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vectors plus randomized traffic against a byte-array model.
module tb_dmem_responder;
  localparam int AW = 14;
  localparam int W  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [0:(1<<AW)-1];

  logic [31:0] obs_rd, exp_rd;
  logic        obs_err, exp_err;
  int          obs_cyc;
  bit          obs_stable, obs_ignored, obs_gone;
  int          acc_edge;

  dmem_responder_if bus();

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  function automatic int acc_size(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Reference: memory as a flat little-endian byte array.
  task automatic model_access(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] op,
                              input logic we, output logic [31:0] rd, output logic err);
    int n, a;
    logic [31:0] v;
    n   = acc_size(op);
    a   = int'(addr % 32'(1 << AW));
    err = 1'b0;
    rd  = 32'b0;
    if ((a % n) != 0) begin
`ifdef DMEM_MISALIGN_ERR_EN
      err = 1'b1;
      return;
`else
      a = a - (a % n);
`endif
    end
    if (we) begin
      for (int i = 0; i < n; i++) mb[a+i] = wd[8*i +: 8];
    end else begin
      v = 32'b0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[a+i]) << (8*i));
      if (n < 4 && !op[2] && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      rd = v;
    end
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] op, input logic we);
    int t = 0;
    while (bus.req_ready !== 1'b1 && t < 100) begin
      @(posedge clock); #1; t++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout: req_ready=%b required 1", bus.req_ready);
    end
    bus.data_addr  = addr;
    bus.data_write = wd;
    bus.MemOp      = op;
    bus.MemWe      = we;
    bus.req_valid  = 1'b1;
    @(posedge clock); #1;
    acc_edge       = edge_cnt;
    bus.req_valid  = 1'b0;
    bus.data_addr  = $urandom;
    bus.data_write = $urandom;
    bus.MemOp      = 3'($urandom_range(0, 7));
    bus.MemWe      = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_resp();
    obs_cyc = 1;
    while (bus.resp_valid !== 1'b1 && obs_cyc < 100) begin
      @(posedge clock); #1; obs_cyc++;
    end
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%b required 1", bus.resp_valid);
    end
  endtask

  task automatic finish_resp(input int hold);
    obs_rd      = bus.data_read;
    obs_err     = bus.resp_err;
    obs_stable  = 1'b1;
    obs_ignored = (bus.req_ready === 1'b0);
    repeat (hold) begin
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.data_addr = $urandom;
      @(posedge clock); #1;
      if (bus.resp_valid !== 1'b1 || bus.data_read !== obs_rd || bus.resp_err !== obs_err) obs_stable = 1'b0;
      if (bus.req_ready !== 1'b0) obs_ignored = 1'b0;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    obs_gone = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1);
  endtask

  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] op,
                        input logic we, input int hold);
    model_access(addr, wd, op, we, exp_rd, exp_err);
    start_req(addr, wd, op, we);
    wait_resp();
    finish_resp(hold);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks += 4;
    if (bus.req_ready !== 1'b1)  begin errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    if (bus.data_read !== 32'b0) begin errors++; $display("FAIL reset_data_read: got %h want 0", bus.data_read); end
    if (bus.resp_err !== 1'b0)   begin errors++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
    reset = 1'b0;
  endtask

  task automatic test_store_latency();
    do_txn(32'h100, 32'h11223344, 3'b010, 1'b1, 0);
    do_txn(32'h40, 32'hCAFEF00D, 3'b010, 1'b1, 0);
    checks += 4;
    if (obs_cyc != W + 2)     begin errors++; $display("FAIL sw_latency: got %0d want %0d", obs_cyc, W + 2); end
    if (obs_rd !== 32'b0)     begin errors++; $display("FAIL sw_data_read: got %h want 0", obs_rd); end
    if (obs_err !== 1'b0)     begin errors++; $display("FAIL sw_resp_err: got %b want 0", obs_err); end
    if (!obs_gone)            begin errors++; $display("FAIL sw_handshake: resp_valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
    do_txn(32'h40, 32'h0, 3'b010, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL lw_after_sw: got %h want cafef00d", obs_rd); end
  endtask

  task automatic test_reset_mid_wait();
    start_req(32'h100, 32'hDEADBEEF, 3'b010, 1'b1);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    checks += 2;
    if (bus.req_ready !== 1'b1)  begin errors++; $display("FAIL rst_wait_req_ready: got %b want 1", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_resp_valid: got %b want 0", bus.resp_valid); end
    @(posedge clock); #1;
    reset = 1'b0;
    do_txn(32'h100, 32'h0, 3'b010, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'h11223344) begin errors++; $display("FAIL rst_dropped_store: got %h want 11223344", obs_rd); end
    start_req(32'h100, 32'h0, 3'b010, 1'b0);
    wait_resp();
    reset = 1'b1;
    #1;
    checks += 2;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    if (bus.data_read !== 32'b0) begin errors++; $display("FAIL rst_resp_data: got %h want 0", bus.data_read); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_extend();
    do_txn(32'h80, 32'h80FF7F01, 3'b010, 1'b1, 0);
    do_txn(32'h83, 32'h0, 3'b000, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_0x83: got %h want ffffff80", obs_rd); end
    do_txn(32'h83, 32'h0, 3'b100, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'h00000080) begin errors++; $display("FAIL lbu_0x83: got %h want 00000080", obs_rd); end
    do_txn(32'h82, 32'h0, 3'b001, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_0x82: got %h want ffff80ff", obs_rd); end
    do_txn(32'h80, 32'h0, 3'b101, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'h00007F01) begin errors++; $display("FAIL lhu_0x80: got %h want 00007f01", obs_rd); end
  endtask

  task automatic test_partial_store();
    do_txn(32'h81, 32'h000000AA, 3'b000, 1'b1, 0);
    do_txn(32'h82, 32'h00001234, 3'b001, 1'b1, 0);
    do_txn(32'h80, 32'h0, 3'b010, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'h1234AA01) begin errors++; $display("FAIL sb_sh_merge: got %h want 1234aa01", obs_rd); end
  endtask

  task automatic test_backpressure_alias();
    logic [31:0] v;
    v = $urandom;
    do_txn(32'h00004040, v, 3'b010, 1'b1, 5);
    checks += 3;
    if (!obs_stable)  begin errors++; $display("FAIL bp_store_stable: got unstable want stable"); end
    if (!obs_ignored) begin errors++; $display("FAIL bp_req_ignored: req_ready went high want 0"); end
    if (!obs_gone)    begin errors++; $display("FAIL bp_release: resp_valid=%b want 0", bus.resp_valid); end
    do_txn(32'h40, 32'h0, 3'b010, 1'b0, 5);
    checks += 2;
    if (obs_rd !== v) begin errors++; $display("FAIL alias_0x4040: got %h want %h", obs_rd, v); end
    if (!obs_stable)  begin errors++; $display("FAIL bp_load_stable: got unstable want stable"); end
  endtask

  task automatic test_misalign();
    do_txn(32'h100, 32'h55667788, 3'b010, 1'b1, 0);
    do_txn(32'h102, 32'h0, 3'b010, 1'b0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
    checks += 2;
    if (obs_err !== 1'b1)  begin errors++; $display("FAIL lw_0x102_err: got %b want 1", obs_err); end
    if (obs_rd !== 32'b0)  begin errors++; $display("FAIL lw_0x102_data: got %h want 0", obs_rd); end
    do_txn(32'h102, 32'hFFFFFFFF, 3'b010, 1'b1, 0);
    checks++;
    if (obs_err !== 1'b1)  begin errors++; $display("FAIL sw_0x102_err: got %b want 1", obs_err); end
    do_txn(32'h100, 32'h0, 3'b010, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'h55667788) begin errors++; $display("FAIL sw_0x102_nowrite: got %h want 55667788", obs_rd); end
`else
    checks += 2;
    if (obs_err !== 1'b0)        begin errors++; $display("FAIL lw_0x102_err: got %b want 0", obs_err); end
    if (obs_rd !== 32'h55667788) begin errors++; $display("FAIL lw_0x102_data: got %h want 55667788", obs_rd); end
    do_txn(32'h101, 32'h0, 3'b001, 1'b0, 0);
    checks++;
    if (obs_rd !== 32'h00007788) begin errors++; $display("FAIL lh_0x101_forced: got %h want 00007788", obs_rd); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) do_txn(32'h200 + 32'(4*i), $urandom, 3'b010, 1'b1, 0);
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      a = (a & ~32'h3FFF) | (32'h200 + 32'($urandom_range(0, 63)));
      do_txn(a, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      checks += 4;
      if (obs_rd !== exp_rd)   begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, obs_rd, exp_rd); end
      if (obs_err !== exp_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", i, obs_err, exp_err); end
      if (obs_cyc != W + 2)    begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, obs_cyc, W + 2); end
      if (!obs_stable || !obs_gone) begin errors++; $display("FAIL rand_handshake[%0d]: stable=%b released=%b want 1/1", i, obs_stable, obs_gone); end
    end
  endtask

  task automatic test_back_to_back();
    int first;
    do_txn(32'h204, 32'h0, 3'b010, 1'b0, 0);
    first = acc_edge;
    do_txn(32'h208, 32'h0, 3'b010, 1'b0, 0);
    checks++;
    if (acc_edge - first != W + 3) begin errors++; $display("FAIL b2b_period: got %0d want %0d", acc_edge - first, W + 3); end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.data_addr  = 32'b0;
    bus.data_write = 32'b0;
    bus.MemOp      = 3'b0;
    bus.MemWe      = 1'b0;
    test_reset();
    test_store_latency();
    test_reset_mid_wait();
    test_extend();
    test_partial_store();
    test_backpressure_alias();
    test_misalign();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
